// File: rtl/controller_pkg.sv
// Shared types and constants for the serial gamepad poller.
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } poller_state_t;

  localparam int REPORT_W = 8;

  // Bit positions in controller_report (serial bit order from the pad)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_START  = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first one a full cycle to resolve
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/controller_poller.sv
// Periodically latches a serial gamepad, shifts in its buttons and
// publishes an active-high report with a valid strobe and press edges.
module controller_poller
  import controller_pkg::*;
#(
  parameter int HALF_DIV = 300,
  parameter int POLL_DIV = 833_333,
  parameter int NBITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pad_data,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic [REPORT_W-1:0] controller_report,
  output logic                report_valid,
  output logic [REPORT_W-1:0] press_edge,
  output logic                overrun
);

  localparam int PW  = $clog2(POLL_DIV);
  localparam int PHW = $clog2(2 * HALF_DIV);
  localparam int KW  = $clog2(NBITS);

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_DIV - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * HALF_DIV - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_DIV - 1);
  localparam logic [KW-1:0]  K_LAST     = KW'(NBITS - 1);

  poller_state_t         r_state;
  poller_state_t         w_nextState;
  logic [PW-1:0]         r_pollCnt;
  logic [PHW-1:0]        r_phase;
  logic [KW-1:0]         r_bitIdx;
  logic [NBITS-1:0]      r_shift;
  logic [REPORT_W-1:0]   r_report;
  logic [REPORT_W-1:0]   r_pressEdge;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  w_tick;
  logic                  w_phaseDone;
  logic                  w_padLatch;
  logic                  w_padClk;
  logic                  w_padSync;
  logic                  w_frameEnd;

  // Pad data idles high (released) so the synchronizer resets to 1
  sync2 #(
    .RST_VAL (1'b1)
  ) u_padSync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (pad_data),
    .o_q     (w_padSync)
  );

  assign w_tick = (r_pollCnt == POLL_LAST);

  // Free-running poll timer, independent of enable and of the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_pollCnt <= '0;
    else if (w_tick)
      r_pollCnt <= '0;
    else
      r_pollCnt <= r_pollCnt + 1'b1;
  end

  // Next-state decode; pad pins are pure functions of the state
  always_comb begin
    w_nextState = r_state;
    w_phaseDone = 1'b0;
    w_padLatch  = 1'b0;
    w_padClk    = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_tick && enable)
          w_nextState = LATCH;
      end
      LATCH: begin
        w_padLatch  = 1'b1;
        w_phaseDone = (r_phase == LATCH_LAST);
        if (w_phaseDone)
          w_nextState = SHIFT_LO;
      end
      SHIFT_LO: begin
        w_padClk    = 1'b0;
        w_phaseDone = (r_phase == HALF_LAST);
        if (w_phaseDone)
          w_nextState = SHIFT_HI;
      end
      SHIFT_HI: begin
        w_phaseDone = (r_phase == HALF_LAST);
        if (w_phaseDone)
          w_nextState = (r_bitIdx == K_LAST) ? DONE : SHIFT_LO;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_frameEnd = (w_nextState == DONE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Phase counter restarts at every phase boundary and rests outside timed states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_phase <= '0;
    else if (w_phaseDone || r_state == IDLE || r_state == DONE)
      r_phase <= '0;
    else
      r_phase <= r_phase + 1'b1;
  end

  // Bit index clears during the latch pulse and advances after each high phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_bitIdx <= '0;
    else if (r_state == LATCH)
      r_bitIdx <= '0;
    else if (r_state == SHIFT_HI && w_phaseDone)
      r_bitIdx <= r_bitIdx + 1'b1;
  end

  // Sample the pad at the end of the low phase, when its data has settled longest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_shift <= '1;
    else if (r_state == SHIFT_LO && w_phaseDone)
      r_shift[r_bitIdx] <= w_padSync;
  end

  // Report, press edges and valid all change together as DONE is entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_report    <= '0;
      r_pressEdge <= '0;
      r_valid     <= 1'b0;
    end else if (w_frameEnd) begin
      r_report    <= ~r_shift;
      r_pressEdge <= ~r_shift & ~r_report;
      r_valid     <= 1'b1;
    end else begin
      r_pressEdge <= '0;
      r_valid     <= 1'b0;
    end
  end

  // A tick that finds the FSM busy is lost; remember that it happened
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_overrun <= 1'b0;
    else if (w_tick && r_state != IDLE)
      r_overrun <= 1'b1;
  end

  assign pad_latch         = w_padLatch;
  assign pad_clk           = w_padClk;
  assign controller_report = r_report;
  assign report_valid      = r_valid;
  assign press_edge        = r_pressEdge;
  assign overrun           = r_overrun;

endmodule

// File: tb/tb_controller_poller.sv
// Directed bench: two pollers (long and short poll period) driven by
// behavioural shift-register gamepads.
module tb_controller_poller;
  import controller_pkg::*;

  logic       clk;
  logic       rstN;
  logic       enA, enB;
  logic       padDataA, padDataB;
  logic       padLatchA, padLatchB;
  logic       padClkA, padClkB;
  logic [7:0] reportA, reportB;
  logic       validA, validB;
  logic [7:0] pressA, pressB;
  logic       overrunA, overrunB;

  logic [7:0] btnA, btnB;
  logic [7:0] shA, shB;
  logic       prevClkA, prevClkB;

  int compared   = 0;
  int mismatched = 0;

  controller_poller #(.HALF_DIV(4), .POLL_DIV(200), .NBITS(8)) dutA (
    .clk               (clk),
    .reset             (rstN),
    .enable            (enA),
    .pad_data          (padDataA),
    .pad_latch         (padLatchA),
    .pad_clk           (padClkA),
    .controller_report (reportA),
    .report_valid      (validA),
    .press_edge        (pressA),
    .overrun           (overrunA)
  );

  controller_poller #(.HALF_DIV(4), .POLL_DIV(60), .NBITS(8)) dutB (
    .clk               (clk),
    .reset             (rstN),
    .enable            (enB),
    .pad_data          (padDataB),
    .pad_latch         (padLatchB),
    .pad_clk           (padClkB),
    .controller_report (reportB),
    .report_valid      (validB),
    .press_edge        (pressB),
    .overrun           (overrunB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gamepad A: parallel load while latched, shift on each pad_clk rise
  always @(negedge clk) begin
    if (padLatchA)
      shA = ~btnA;
    else if (padClkA && !prevClkA)
      shA = {1'b1, shA[7:1]};
    prevClkA = padClkA;
    padDataA = shA[0];
  end

  // Gamepad B: same behaviour
  always @(negedge clk) begin
    if (padLatchB)
      shB = ~btnB;
    else if (padClkB && !prevClkB)
      shB = {1'b1, shB[7:1]};
    prevClkB = padClkB;
    padDataB = shB[0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitLatch(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if ((which == 0) ? padLatchA : padLatchB) begin
        n = i;
        break;
      end
    end
  endtask

  // Called on the sample where the latch was first seen high (rel 0)
  task automatic applyStimulus(input int which, input int dropEnRel,
                               output int latchLen, output int lowPulses,
                               output int badLow, output int validRel,
                               output logic [7:0] rep, output logic [7:0] pe,
                               output int ovrRise);
    int   lowLen;
    logic prevC;
    logic l, c, v, o;
    latchLen  = 0;
    lowPulses = 0;
    badLow    = 0;
    validRel  = -1;
    ovrRise   = -1;
    rep       = 8'h00;
    pe        = 8'h00;
    lowLen    = 0;
    prevC     = 1'b1;
    for (int r = 0; r <= 100; r++) begin
      if (r > 0) begin
        @(posedge clk);
        #1;
      end
      if (r == dropEnRel) enA = 1'b0;
      l = (which == 0) ? padLatchA : padLatchB;
      c = (which == 0) ? padClkA   : padClkB;
      v = (which == 0) ? validA    : validB;
      o = (which == 0) ? overrunA  : overrunB;
      if (l) latchLen++;
      if (!c)
        lowLen++;
      else if (!prevC) begin
        lowPulses++;
        if (lowLen != 4) badLow++;
        lowLen = 0;
      end
      prevC = c;
      if (o && ovrRise < 0) ovrRise = r;
      if (v) begin
        validRel = r;
        rep = (which == 0) ? reportA : reportB;
        pe  = (which == 0) ? pressA  : pressB;
        break;
      end
    end
  endtask

  int         n, latchLen, lowPulses, badLow, validRel, ovrRise, seen;
  logic [7:0] rep, pe;

  initial begin
    rstN     = 1'b0;
    enA      = 1'b1;
    enB      = 1'b0;
    btnA     = 8'h00;
    btnB     = 8'h00;
    shA      = 8'hFF;
    shB      = 8'hFF;
    prevClkA = 1'b1;
    prevClkB = 1'b1;
    padDataA = 1'b1;
    padDataB = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_latch",  padLatchA, 0);
    checkOutput("rst_padclk", padClkA,   1);
    checkOutput("rst_report", reportA,   0);
    checkOutput("rst_valid",  validA,    0);
    checkOutput("rst_press",  pressA,    0);
    checkOutput("rst_ovr",    overrunA,  0);
    @(negedge clk);
    rstN = 1'b1;

    // Frame 1: all released, full timing check
    $display("[TB] frame 1 timing");
    waitLatch(0, 250, n);
    checkOutput("f1_latch_cycle", n, 200);
    applyStimulus(0, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("f1_latch_len",   latchLen,  8);
    checkOutput("f1_clk_pulses",  lowPulses, 8);
    checkOutput("f1_clk_low_len", badLow,    0);
    checkOutput("f1_valid_rel",   validRel,  72);
    checkOutput("f1_report",      rep,       8'h00);
    checkOutput("f1_press",       pe,        8'h00);
    @(posedge clk);
    #1;
    checkOutput("f1_valid_1cyc",  validA,    0);

    // Frame 2: start pressed
    btnA = 8'(1 << BTN_START);
    waitLatch(0, 250, n);
    checkOutput("f2_period", n, 127);
    applyStimulus(0, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("f2_report", rep, 8'h10);
    checkOutput("f2_press",  pe,  8'h10);
    @(posedge clk);
    #1;
    checkOutput("f2_press_1cyc", pressA, 8'h00);
    checkOutput("f2_hold",       reportA, 8'h10);

    // Frame 3: start still held, no new edge
    waitLatch(0, 250, n);
    applyStimulus(0, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("f3_report", rep, 8'h10);
    checkOutput("f3_press",  pe,  8'h00);
    @(posedge clk);
    #1;

    // Frame 4: all released
    btnA = 8'h00;
    waitLatch(0, 250, n);
    applyStimulus(0, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("f4_report", rep, 8'h00);
    checkOutput("f4_press",  pe,  8'h00);
    @(posedge clk);
    #1;

    // Frame 5: bits 0 and 7
    btnA = 8'(1 << BTN_A) | 8'(1 << BTN_RIGHT);
    waitLatch(0, 250, n);
    applyStimulus(0, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("f5_report", rep, 8'h81);
    checkOutput("f5_press",  pe,  8'h81);
    @(posedge clk);
    #1;

    // Disabled for three poll periods
    $display("[TB] enable low");
    enA  = 1'b0;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (padLatchA) seen++;
    end
    checkOutput("dis_no_latch", seen,     0);
    checkOutput("dis_report",   reportA,  8'h81);
    checkOutput("dis_overrun",  overrunA, 0);

    // Re-enable, then drop enable during SHIFT_LO of bit 0
    btnA = 8'(1 << BTN_A) | 8'(1 << BTN_START);
    enA  = 1'b1;
    waitLatch(0, 250, n);
    checkOutput("reen_period", n, 127);
    applyStimulus(0, 10, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("drop_valid_rel", validRel, 72);
    checkOutput("drop_report",    rep,      8'h11);
    checkOutput("drop_press",     pe,       8'h10);
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk);
      #1;
      if (padLatchA) seen++;
    end
    checkOutput("drop_no_next", seen, 0);

    // Short poll period on the second instance: overrun behaviour
    $display("[TB] overrun");
    checkOutput("b_ovr_idle", overrunB, 0);
    btnB = 8'(1 << BTN_DOWN) | 8'(1 << BTN_LEFT);
    enB  = 1'b1;
    waitLatch(1, 70, n);
    checkOutput("b_latch_found", (n >= 1 && n <= 60), 1);
    applyStimulus(1, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("b_ovr_rise",  ovrRise,  60);
    checkOutput("b_valid_rel", validRel, 72);
    checkOutput("b_report",    rep,      8'h60);
    checkOutput("b_press",     pe,       8'h60);
    @(posedge clk);
    #1;
    waitLatch(1, 100, n);
    checkOutput("b_skip_tick", n, 47);
    applyStimulus(1, -1, latchLen, lowPulses, badLow, validRel, rep, pe, ovrRise);
    checkOutput("b2_valid_rel", validRel, 72);
    checkOutput("b2_press",     pe,       8'h00);
    checkOutput("b2_ovr_stuck", overrunB, 1);

    // Asynchronous reset in SHIFT_HI of bit 3
    $display("[TB] async reset mid-frame");
    enA = 1'b1;
    waitLatch(0, 250, n);
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_rst_padclk", padClkA, 1);
    checkOutput("pre_rst_report", reportA, 8'h11);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_latch",  padLatchA, 0);
    checkOutput("arst_padclk", padClkA,   1);
    checkOutput("arst_report", reportA,   8'h00);
    checkOutput("arst_ovr_b",  overrunB,  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    waitLatch(0, 250, n);
    checkOutput("arst_first_frame", n, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
